led_chain_tx: RTL and testbench



---
 rtl/led_tx_pkg.sv | 21 ++
 rtl/light_pingpong_ram.sv | 40 ++++
 rtl/led_chain_tx.sv | 195 +++++++++++++++++++
 tb/tb_led_chain_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_tx_pkg.sv
// Shared types and widths for the LED chain transmitter.
package led_tx_pkg;

    localparam int IDX_W = 9;
    localparam int DAT_W = 16;
    localparam int BIT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        GAP
    } tx_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/light_pingpong_ram.sv
// Two-bank zone buffer: one write port, one registered read port.
module light_pingpong_ram
    import led_tx_pkg::*;
#(
    parameter int ZONE_NUM = 384,
    parameter int AW       = cnt_w(ZONE_NUM)
) (
    input  logic             sys_clk,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DAT_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_sel,
    input  logic [AW-1:0]    rd_addr,
    output logic [DAT_W-1:0] rd_data
);

    logic [DAT_W-1:0] bank0 [ZONE_NUM];
    logic [DAT_W-1:0] bank1 [ZONE_NUM];

    // Write into whichever bank is currently being filled.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            if (wr_sel) begin
                bank1[wr_addr] <= wr_data;
            end else begin
                bank0[wr_addr] <= wr_data;
            end
        end
    end

    // Registered read; data holds until the next read enable.
    always_ff @(posedge sys_clk) begin
        if (rd_en) begin
            rd_data <= rd_sel ? bank1[rd_addr] : bank0[rd_addr];
        end
    end

endmodule

// File: rtl/led_chain_tx.sv
// Buffers one frame of zone brightness and shifts it into a daisy-chained
// LED driver string, latching it at the end so a frame updates atomically.
//
// state | meaning
// IDLE  | waiting for a refresh or a queued frame
// LOAD  | read of the last zone issued
// SHIFT | zones sent last-to-first, MSB first, sclk low then high per bit
// LATCH | led_lat high for LAT_W cycles
// GAP   | quiet time before the next frame may start
module led_chain_tx
    import led_tx_pkg::*;
#(
    parameter int ZONE_NUM = 384,
    parameter int CLK_DIV  = 4,
    parameter int LAT_W    = 4,
    parameter int GAP_W    = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             light_vld,
    input  logic [IDX_W-1:0] light_index,
    input  logic [DAT_W-1:0] mapped_light,
    input  logic             light_refresh,
    output logic             led_sclk,
    output logic             led_sdi,
    output logic             led_lat,
    output logic             busy,
    output logic             frame_drop
);

    localparam int AW      = cnt_w(ZONE_NUM);
    localparam int DIV_W   = cnt_w(CLK_DIV);
    localparam int TMR_MAX = (LAT_W > GAP_W) ? LAT_W : GAP_W;
    localparam int TMR_W   = cnt_w(TMR_MAX);

    localparam logic [IDX_W-1:0] ZONE_LAST = IDX_W'(ZONE_NUM - 1);
    localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] LAT_LOAD  = TMR_W'(LAT_W - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'((GAP_W > 0) ? GAP_W - 1 : 0);

    tx_state_t        state, state_nxt;
    logic [IDX_W-1:0] zone_cnt, zone_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             phase, phase_nxt;

    logic             wr_sel, rd_sel, pending;
    logic             start;
    logic             wr_en;
    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;
    logic [DAT_W-1:0] rd_data;

    // Out-of-range zone writes are dropped rather than aliased.
    assign wr_en = light_vld && (light_index <= ZONE_LAST);
    assign start = (state == IDLE) && (light_refresh || pending);

    light_pingpong_ram #(
        .ZONE_NUM (ZONE_NUM),
        .AW       (AW)
    ) u_ram (
        .sys_clk (sys_clk),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (light_index[AW-1:0]),
        .wr_data (mapped_light),
        .rd_en   (rd_en),
        .rd_sel  (rd_sel),
        .rd_addr (rd_addr[AW-1:0]),
        .rd_data (rd_data)
    );

    // Bank swap on frame start, one-deep refresh queue, drop pulse on overflow.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b1;
            pending    <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= 1'b0;
            if (start) begin
                rd_sel  <= wr_sel;
                wr_sel  <= ~wr_sel;
                pending <= pending && light_refresh;
            end else if (light_refresh) begin
                if (pending) begin
                    frame_drop <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end
        end
    end

    // FSM and serializer counters.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            zone_cnt <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            tmr      <= '0;
            phase    <= 1'b0;
        end else begin
            state    <= state_nxt;
            zone_cnt <= zone_nxt;
            bit_cnt  <= bit_nxt;
            div_cnt  <= div_nxt;
            tmr      <= tmr_nxt;
            phase    <= phase_nxt;
        end
    end

    // Next zone is read on the last cycle of the current zone so rd_data
    // switches exactly at the zone boundary.
    always_comb begin
        state_nxt = state;
        zone_nxt  = zone_cnt;
        bit_nxt   = bit_cnt;
        div_nxt   = div_cnt;
        tmr_nxt   = tmr;
        phase_nxt = phase;
        rd_en     = 1'b0;
        rd_addr   = ZONE_LAST;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                rd_en     = 1'b1;
                zone_nxt  = ZONE_LAST;
                bit_nxt   = 4'd15;
                div_nxt   = DIV_LOAD;
                phase_nxt = 1'b0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (div_cnt != '0) begin
                    div_nxt = div_cnt - DIV_W'(1);
                end else begin
                    div_nxt = DIV_LOAD;
                    if (!phase) begin
                        phase_nxt = 1'b1;
                    end else begin
                        phase_nxt = 1'b0;
                        if (bit_cnt != '0) begin
                            bit_nxt = bit_cnt - BIT_W'(1);
                        end else begin
                            bit_nxt = 4'd15;
                            if (zone_cnt != '0) begin
                                zone_nxt = zone_cnt - IDX_W'(1);
                                rd_en    = 1'b1;
                                rd_addr  = zone_cnt - IDX_W'(1);
                            end else begin
                                tmr_nxt   = LAT_LOAD;
                                state_nxt = LATCH;
                            end
                        end
                    end
                end
            end
            LATCH: begin
                if (tmr != '0) begin
                    tmr_nxt = tmr - TMR_W'(1);
                end else if (GAP_W > 0) begin
                    tmr_nxt   = GAP_LOAD;
                    state_nxt = GAP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                if (tmr != '0) begin
                    tmr_nxt = tmr - TMR_W'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so reset clears them immediately.
    assign busy     = (state != IDLE);
    assign led_sclk = (state == SHIFT) && phase;
    assign led_sdi  = (state == SHIFT) && rd_data[bit_cnt];
    assign led_lat  = (state == LATCH);

endmodule

// File: tb/tb_led_chain_tx.sv
// Directed bench for led_chain_tx with a small 4-zone configuration.
module tb_led_chain_tx;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        light_vld;
    logic [8:0]  light_index;
    logic [15:0] mapped_light;
    logic        light_refresh;
    logic        led_sclk, led_sdi, led_lat, busy, frame_drop;

    int checks = 0;
    int fails  = 0;

    // Monitor state, updated on negedges.
    logic [63:0] rx = '0;
    logic        sclk_q = 1'b0;
    logic        lat_q = 1'b0;
    int          rise_cnt = 0;
    int          lat_cyc = 0;
    int          lat_pulses = 0;
    int          busy_cyc = 0;
    int          drop_cyc = 0;

    // Snapshots.
    int r0, l0, lp0, b0, d0;

    led_chain_tx #(
        .ZONE_NUM (4),
        .CLK_DIV  (2),
        .LAT_W    (3),
        .GAP_W    (2)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .light_vld     (light_vld),
        .light_index   (light_index),
        .mapped_light  (mapped_light),
        .light_refresh (light_refresh),
        .led_sclk      (led_sclk),
        .led_sdi       (led_sdi),
        .led_lat       (led_lat),
        .busy          (busy),
        .frame_drop    (frame_drop)
    );

    always #5 sys_clk = ~sys_clk;

    // Capture sdi on every sclk rise and count latch, busy and drop cycles.
    always @(negedge sys_clk) begin
        sclk_q <= led_sclk;
        lat_q  <= led_lat;
        if (led_sclk && !sclk_q) begin
            rise_cnt <= rise_cnt + 1;
            rx       <= {rx[62:0], led_sdi};
        end
        if (led_lat) lat_cyc <= lat_cyc + 1;
        if (led_lat && !lat_q) lat_pulses <= lat_pulses + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        if (frame_drop) drop_cyc <= drop_cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_zone(input logic [8:0] idx, input logic [15:0] val);
        light_vld    = 1'b1;
        light_index  = idx;
        mapped_light = val;
        @(negedge sys_clk);
        light_vld    = 1'b0;
    endtask

    task automatic write_frame(input logic [15:0] z0, input logic [15:0] z1,
                               input logic [15:0] z2, input logic [15:0] z3);
        write_zone(9'd0, z0);
        write_zone(9'd1, z1);
        write_zone(9'd2, z2);
        write_zone(9'd3, z3);
    endtask

    task automatic pulse_refresh();
        light_refresh = 1'b1;
        @(negedge sys_clk);
        light_refresh = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 600) begin
            @(negedge sys_clk);
            n++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    task automatic snap();
        #1;
        r0  = rise_cnt;
        l0  = lat_cyc;
        lp0 = lat_pulses;
        b0  = busy_cyc;
        d0  = drop_cyc;
        @(negedge sys_clk);
    endtask

    initial begin
        sys_rst       = 1'b1;
        light_vld     = 1'b0;
        light_index   = '0;
        mapped_light  = '0;
        light_refresh = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_outputs", 64'({led_sclk, led_sdi, led_lat, busy, frame_drop}), 64'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("idle_after_rst", 64'({led_sclk, led_sdi, led_lat, busy, frame_drop}), 64'd0);

        // Basic frame with first-bit timing.
        write_frame(16'h0001, 16'h8000, 16'hA5A5, 16'hFFFF);
        snap();
        pulse_refresh();
        chk("busy_rise", 64'(busy), 64'd1);
        @(negedge sys_clk);
        chk("first_sdi", 64'(led_sdi), 64'd1);
        chk("sclk_low_t2", 64'(led_sclk), 64'd0);
        @(negedge sys_clk);
        chk("sclk_low_t3", 64'(led_sclk), 64'd0);
        @(negedge sys_clk);
        chk("first_rise", 64'(led_sclk), 64'd1);
        wait_idle("f1_idle");
        #1;
        chk("f1_data", rx, 64'hFFFF_A5A5_8000_0001);
        chk("f1_rises", 64'(rise_cnt - r0), 64'd64);
        chk("f1_lat_cyc", 64'(lat_cyc - l0), 64'd3);
        chk("f1_lat_pulse", 64'(lat_pulses - lp0), 64'd1);
        chk("f1_busy_len", 64'(busy_cyc - b0), 64'd262);
        @(negedge sys_clk);

        // Out-of-range writes must not alias onto real zones.
        write_frame(16'h0001, 16'h8000, 16'hA5A5, 16'hFFFF);
        write_zone(9'd4, 16'h1234);
        write_zone(9'd5, 16'h5678);
        write_zone(9'd511, 16'h9ABC);
        pulse_refresh();
        wait_idle("f2_idle");
        #1;
        chk("f2_oob_data", rx, 64'hFFFF_A5A5_8000_0001);
        @(negedge sys_clk);

        // Refresh while busy queues one frame that starts right after.
        write_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        snap();
        pulse_refresh();
        write_zone(9'd0, 16'hC3C3);
        write_zone(9'd1, 16'h9999);
        write_zone(9'd1, 16'h0000);
        write_zone(9'd2, 16'h7E7E);
        write_zone(9'd3, 16'h8001);
        pulse_refresh();
        wait_idle("f3a_idle");
        chk("f3a_data", rx, 64'h4444_3333_2222_1111);
        @(negedge sys_clk);
        chk("pend_start", 64'(busy), 64'd1);
        wait_idle("f3b_idle");
        #1;
        chk("f3b_data", rx, 64'h8001_7E7E_0000_C3C3);
        chk("f3_rises", 64'(rise_cnt - r0), 64'd128);
        chk("f3_no_drop", 64'(drop_cyc - d0), 64'd0);
        @(negedge sys_clk);

        // Two extra refreshes: one queued, one dropped.
        write_frame(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        snap();
        pulse_refresh();
        write_frame(16'hAAAA, 16'h5555, 16'hF00F, 16'h0FF0);
        pulse_refresh();
        repeat (5) @(negedge sys_clk);
        pulse_refresh();
        repeat (3) @(negedge sys_clk);
        #1;
        chk("drop_once", 64'(drop_cyc - d0), 64'd1);
        @(negedge sys_clk);
        wait_idle("f4a_idle");
        chk("f4a_data", rx, 64'h0708_0506_0304_0102);
        @(negedge sys_clk);
        wait_idle("f4b_idle");
        chk("f4b_data", rx, 64'h0FF0_F00F_5555_AAAA);
        repeat (20) @(negedge sys_clk);
        chk("f4_no_third", 64'(busy), 64'd0);
        chk("f4_rises", 64'(rise_cnt - r0), 64'd128);
        chk("f4_drop_total", 64'(drop_cyc - d0), 64'd1);

        // Write and refresh in the same cycle land in the committed frame.
        light_vld     = 1'b1;
        light_index   = 9'd2;
        mapped_light  = 16'h0F0F;
        light_refresh = 1'b1;
        @(negedge sys_clk);
        light_vld     = 1'b0;
        light_refresh = 1'b0;
        wait_idle("f5_idle");
        chk("f5_same_cycle", rx, 64'h0708_0F0F_0304_0102);
        @(negedge sys_clk);

        // Reset in the middle of SHIFT abandons the frame without a latch.
        snap();
        pulse_refresh();
        repeat (40) @(negedge sys_clk);
        begin
            int n = 0;
            while (!led_sclk && n < 10) begin
                @(negedge sys_clk);
                n++;
            end
        end
        chk("mid_sclk_high", 64'(led_sclk), 64'd1);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("rst_async", 64'({led_sclk, led_sdi, led_lat, busy, frame_drop}), 64'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (10) @(negedge sys_clk);
        #1;
        chk("rst_no_latch", 64'(lat_pulses - lp0), 64'd0);
        @(negedge sys_clk);

        write_frame(16'hDEAD, 16'hBEEF, 16'h1357, 16'h2468);
        snap();
        pulse_refresh();
        wait_idle("f6_idle");
        #1;
        chk("f6_data", rx, 64'h2468_1357_BEEF_DEAD);
        chk("f6_rises", 64'(rise_cnt - r0), 64'd64);
        chk("f6_lat_cyc", 64'(lat_cyc - l0), 64'd3);
        chk("f6_busy_len", 64'(busy_cyc - b0), 64'd262);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
